// File: rtl/spi_mem_arbiter_pkg.sv
// Shared types for the SPI/core SRAM arbiter.
// Widths here match the arbiter's default parameters.
package spi_mem_arbiter_pkg;

    localparam int MSG_W  = 32;
    localparam int ADDR_W = 16;
    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_SPI_RD,
        GNT_CORE_RD
    } grant_tag_t;

    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] address;
        logic [MSG_W-1:0]  wdata;
    } spi_req_t;

endpackage

// File: rtl/spi_request_buffer.sv
// One-entry SPI request capture with code filter and overrun detection.
// A pulse landing in the same cycle the entry drains replaces it cleanly.
module spi_request_buffer
    import spi_mem_arbiter_pkg::*;
#(
    parameter int CODE_BIT_WIDTH = CODE_W,
    parameter int MEM_CODE       = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      write_new,
    input  logic                      read_sync,
    input  logic [CODE_BIT_WIDTH-1:0] code,
    input  logic [ADDR_W-1:0]         address,
    input  logic [MSG_W-1:0]          wdata,
    input  logic                      drain,
    input  logic                      overrun_clear,
    output logic                      pending_valid,
    output spi_req_t                  req,
    output logic                      overrun
);

    logic code_hit;
    logic accept_wr;
    logic accept_rd;
    logic blocked;
    logic capture;
    logic overrun_event;

    always_comb begin
        code_hit      = (code == CODE_BIT_WIDTH'(MEM_CODE));
        accept_wr     = write_new & code_hit;
        accept_rd     = read_sync & code_hit;
        blocked       = (accept_wr | accept_rd) & pending_valid & ~drain;
        capture       = (accept_wr | accept_rd) & ~blocked;
        overrun_event = (accept_wr & accept_rd) | blocked;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_valid <= 1'b0;
            req           <= '0;
            overrun       <= 1'b0;
        end else begin
            if (capture) begin
                pending_valid <= 1'b1;
                req.is_write  <= accept_wr;
                req.address   <= address;
                req.wdata     <= wdata;
            end else if (drain) begin
                pending_valid <= 1'b0;
            end
            // A fresh overrun wins over a clear in the same cycle
            if (overrun_event) begin
                overrun <= 1'b1;
            end else if (overrun_clear) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Fixed-priority SRAM arbiter: SPI requests first, core requester second.
// Read data returns to whichever side owned the previous cycle's read.
module spi_mem_arbiter
    import spi_mem_arbiter_pkg::*;
#(
    parameter int MESSAGE_BIT_WIDTH = MSG_W,
    parameter int CODE_BIT_WIDTH    = CODE_W,
    parameter int ADDRESS_BIT_WIDTH = ADDR_W,
    parameter int MEM_CODE          = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_write_new,
    input  logic                         spi_read_sync,
    input  logic [CODE_BIT_WIDTH-1:0]    spi_code,
    input  logic [ADDRESS_BIT_WIDTH-1:0] spi_address,
    input  logic [MESSAGE_BIT_WIDTH-1:0] spi_wdata,
    output logic [MESSAGE_BIT_WIDTH-1:0] spi_rdata,
    output logic                         spi_overrun,
    input  logic                         core_req,
    input  logic                         core_we,
    input  logic [ADDRESS_BIT_WIDTH-1:0] core_addr,
    input  logic [MESSAGE_BIT_WIDTH-1:0] core_wdata,
    output logic                         core_gnt,
    output logic                         core_rvalid,
    output logic [MESSAGE_BIT_WIDTH-1:0] core_rdata,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [ADDRESS_BIT_WIDTH-1:0] mem_addr,
    output logic [MESSAGE_BIT_WIDTH-1:0] mem_wdata,
    input  logic [MESSAGE_BIT_WIDTH-1:0] mem_rdata,
    input  logic                         overrun_clear
);

    logic       pending_valid;
    spi_req_t   req;
    grant_tag_t tag;
    grant_tag_t tag_next;

    spi_request_buffer #(
        .CODE_BIT_WIDTH (CODE_BIT_WIDTH),
        .MEM_CODE       (MEM_CODE)
    ) u_buffer (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_new     (spi_write_new),
        .read_sync     (spi_read_sync),
        .code          (spi_code),
        .address       (spi_address),
        .wdata         (spi_wdata),
        .drain         (pending_valid),
        .overrun_clear (overrun_clear),
        .pending_valid (pending_valid),
        .req           (req),
        .overrun       (spi_overrun)
    );

    // Gated by rst_n so nothing reaches the SRAM while reset is held
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        core_gnt  = 1'b0;
        tag_next  = GNT_NONE;
        if (rst_n) begin
            if (pending_valid) begin
                mem_en    = 1'b1;
                mem_we    = req.is_write;
                mem_addr  = req.address;
                mem_wdata = req.wdata;
                if (!req.is_write) tag_next = GNT_SPI_RD;
            end else if (core_req) begin
                mem_en    = 1'b1;
                mem_we    = core_we;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                core_gnt  = 1'b1;
                if (!core_we) tag_next = GNT_CORE_RD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag       <= GNT_NONE;
            spi_rdata <= '0;
        end else begin
            tag <= tag_next;
            if (tag == GNT_SPI_RD) spi_rdata <= mem_rdata;
        end
    end

    assign core_rvalid = (tag == GNT_CORE_RD);
    assign core_rdata  = mem_rdata;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: random mixed traffic against a reference
// model, then directed write/read/filter/overrun/reset/streaming steps.
module tb_spi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_write_new;
    logic        spi_read_sync;
    logic [3:0]  spi_code;
    logic [15:0] spi_address;
    logic [31:0] spi_wdata;
    logic [31:0] spi_rdata;
    logic        spi_overrun;
    logic        core_req;
    logic        core_we;
    logic [15:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        overrun_clear;

    int checks = 0;
    int errors = 0;

    logic [31:0] sram    [0:255];
    logic [31:0] ref_mem [0:255];

    always #5 clk = ~clk;

    spi_mem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi_write_new (spi_write_new),
        .spi_read_sync (spi_read_sync),
        .spi_code      (spi_code),
        .spi_address   (spi_address),
        .spi_wdata     (spi_wdata),
        .spi_rdata     (spi_rdata),
        .spi_overrun   (spi_overrun),
        .core_req      (core_req),
        .core_we       (core_we),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_gnt      (core_gnt),
        .core_rvalid   (core_rvalid),
        .core_rdata    (core_rdata),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .overrun_clear (overrun_clear)
    );

    // Single-port SRAM, one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        spi_write_new = 1'b0;
        spi_read_sync = 1'b0;
        spi_code      = 4'd1;
        spi_address   = '0;
        spi_wdata     = '0;
        core_req      = 1'b0;
        core_we       = 1'b0;
        core_addr     = '0;
        core_wdata    = '0;
        overrun_clear = 1'b0;
    endtask

    // Reference model state
    bit          m_pend;
    bit          m_pend_we;
    logic [15:0] m_pend_a;
    logic [31:0] m_pend_d;
    bit          m_rv;
    logic [31:0] m_rv_d;
    int          spi_ret_cnt;
    logic [31:0] spi_ret_d;
    logic [31:0] m_spi_rdata;
    bit          c_active;
    bit          c_we;
    logic [15:0] c_addr;
    logic [31:0] c_wd;

    initial begin
        bit          issue;
        bit          new_rv;
        logic [31:0] new_rv_d;
        int          gap;
        logic [31:0] tmp;

        idle_inputs();
        rst_n     = 1'b0;
        core_req  = 1'b1;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end

        // Reset state, core_req held high
        @(negedge clk); #1;
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_core_gnt", 32'(core_gnt), 0);
        chk("rst_core_rvalid", 32'(core_rvalid), 0);
        chk("rst_spi_rdata", spi_rdata, 0);
        chk("rst_overrun", 32'(spi_overrun), 0);

        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // Random mixed traffic
        m_pend = 0; m_rv = 0; spi_ret_cnt = 0;
        m_spi_rdata = '0; c_active = 0; gap = 10;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            spi_write_new = 1'b0;
            spi_read_sync = 1'b0;
            if (!c_active && cyc < 390 && $urandom_range(0, 2) != 0) begin
                c_active = 1;
                c_we     = 1'($urandom_range(0, 1));
                c_addr   = 16'($urandom_range(0, 15));
                c_wd     = $urandom;
            end
            core_req   = c_active;
            core_we    = c_we;
            core_addr  = c_addr;
            core_wdata = c_wd;
            gap++;
            if (gap >= 4 && cyc < 390 && $urandom_range(0, 2) == 0) begin
                gap = 0;
                if ($urandom_range(0, 1) == 1) spi_write_new = 1'b1;
                else                           spi_read_sync = 1'b1;
                spi_code    = ($urandom_range(0, 3) == 0) ? 4'd2 : 4'd1;
                spi_address = 16'($urandom_range(0, 15));
                spi_wdata   = $urandom;
            end
            #1;
            issue = m_pend;
            chk("rnd_gnt", 32'(core_gnt), 32'(c_active & ~issue));
            chk("rnd_mem_en", 32'(mem_en), 32'(issue | c_active));
            if (issue) begin
                chk("rnd_spi_addr", 32'(mem_addr), 32'(m_pend_a));
                chk("rnd_spi_we", 32'(mem_we), 32'(m_pend_we));
                if (m_pend_we) chk("rnd_spi_wdata", mem_wdata, m_pend_d);
            end
            chk("rnd_rvalid", 32'(core_rvalid), 32'(m_rv));
            if (m_rv) chk("rnd_rdata", core_rdata, m_rv_d);
            chk("rnd_spi_rdata", spi_rdata, m_spi_rdata);
            chk("rnd_overrun", 32'(spi_overrun), 0);

            if (spi_ret_cnt > 0) begin
                spi_ret_cnt--;
                if (spi_ret_cnt == 0) m_spi_rdata = spi_ret_d;
            end
            new_rv   = 0;
            new_rv_d = '0;
            if (issue) begin
                if (m_pend_we) ref_mem[m_pend_a[7:0]] = m_pend_d;
                else begin
                    spi_ret_cnt = 1;
                    spi_ret_d   = ref_mem[m_pend_a[7:0]];
                end
            end else if (c_active) begin
                if (c_we) ref_mem[c_addr[7:0]] = c_wd;
                else begin
                    new_rv   = 1;
                    new_rv_d = ref_mem[c_addr[7:0]];
                end
                c_active = 0;
            end
            m_rv   = new_rv;
            m_rv_d = new_rv_d;
            m_pend = (spi_write_new | spi_read_sync) && spi_code == 4'd1;
            m_pend_we = spi_write_new;
            m_pend_a  = spi_address;
            m_pend_d  = spi_wdata;
        end

        // SPI write
        @(negedge clk);
        idle_inputs();
        spi_write_new = 1'b1;
        spi_address   = 16'h0010;
        spi_wdata     = 32'hDEADBEEF;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("wr_mem_en", 32'(mem_en), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h10);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        ref_mem[8'h10] = 32'hDEADBEEF;

        // SPI read during core traffic
        @(negedge clk);
        core_req      = 1'b1;
        core_addr     = 16'd3;
        spi_read_sync = 1'b1;
        spi_address   = 16'h0010;
        #1;
        chk("rd_n0_gnt", 32'(core_gnt), 1);
        @(negedge clk);
        spi_read_sync = 1'b0;
        core_addr     = 16'd4;
        #1;
        chk("rd_n1_gnt", 32'(core_gnt), 0);
        chk("rd_n1_addr", 32'(mem_addr), 32'h10);
        chk("rd_n1_we", 32'(mem_we), 0);
        chk("rd_n1_rvalid", 32'(core_rvalid), 1);
        chk("rd_n1_rdata", core_rdata, ref_mem[3]);
        @(negedge clk);
        #1;
        chk("rd_n2_gnt", 32'(core_gnt), 1);
        chk("rd_n2_rvalid", 32'(core_rvalid), 0);
        @(negedge clk);
        core_req = 1'b0;
        #1;
        chk("rd_n3_spi_rdata", spi_rdata, 32'hDEADBEEF);
        chk("rd_n3_rvalid", 32'(core_rvalid), 1);
        chk("rd_n3_rdata", core_rdata, ref_mem[4]);
        @(negedge clk);
        #1;
        chk("rd_n4_rvalid", 32'(core_rvalid), 0);

        // Code filter
        @(negedge clk);
        spi_write_new = 1'b1;
        spi_code      = 4'd2;
        spi_address   = 16'h0030;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("flt_mem_en", 32'(mem_en), 0);
        chk("flt_overrun", 32'(spi_overrun), 0);

        // Simultaneous pulses: write wins, overrun sticks
        @(negedge clk);
        spi_write_new = 1'b1;
        spi_read_sync = 1'b1;
        spi_address   = 16'h0040;
        spi_wdata     = 32'h12345678;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("ovr_mem_en", 32'(mem_en), 1);
        chk("ovr_mem_we", 32'(mem_we), 1);
        chk("ovr_mem_addr", 32'(mem_addr), 32'h40);
        chk("ovr_flag", 32'(spi_overrun), 1);
        ref_mem[8'h40] = 32'h12345678;
        repeat (3) @(negedge clk);
        #1;
        chk("ovr_hold", 32'(spi_overrun), 1);
        chk("ovr_idle_mem_en", 32'(mem_en), 0);
        // Clear colliding with a new overrun keeps the flag
        @(negedge clk);
        overrun_clear = 1'b1;
        spi_write_new = 1'b1;
        spi_read_sync = 1'b1;
        spi_address   = 16'h0041;
        spi_wdata     = 32'h0BADF00D;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("ovr_clr_collide", 32'(spi_overrun), 1);
        ref_mem[8'h41] = 32'h0BADF00D;
        @(negedge clk);
        overrun_clear = 1'b1;
        @(negedge clk);
        overrun_clear = 1'b0;
        #1;
        chk("ovr_cleared", 32'(spi_overrun), 0);

        // Pulse arriving while the entry drains is captured cleanly
        @(negedge clk);
        spi_write_new = 1'b1;
        spi_address   = 16'h0050;
        spi_wdata     = 32'hA5A5C3C3;
        @(negedge clk);
        spi_write_new = 1'b0;
        spi_read_sync = 1'b1;
        #1;
        chk("drn_wr_en", 32'(mem_en & mem_we), 1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("drn_rd_addr", 32'(mem_addr), 32'h50);
        chk("drn_rd_we", 32'(mem_we), 0);
        chk("drn_overrun", 32'(spi_overrun), 0);
        ref_mem[8'h50] = 32'hA5A5C3C3;
        repeat (2) @(negedge clk);
        #1;
        chk("drn_spi_rdata", spi_rdata, 32'hA5A5C3C3);

        // Reset mid-operation with a pending write and a core read in flight
        @(negedge clk);
        spi_write_new = 1'b1;
        spi_address   = 16'h0020;
        spi_wdata     = 32'hBAD0BAD0;
        core_req      = 1'b1;
        core_addr     = 16'd7;
        #1;
        chk("mid_gnt", 32'(core_gnt), 1);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("mid_mem_en", 32'(mem_en), 0);
        chk("mid_rvalid", 32'(core_rvalid), 0);
        chk("mid_spi_rdata", spi_rdata, 0);
        chk("mid_overrun", 32'(spi_overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_mem_en", 32'(mem_en), 0);
            chk("post_rvalid", 32'(core_rvalid), 0);
        end
        @(negedge clk);
        core_req  = 1'b1;
        core_addr = 16'h0020;
        @(negedge clk);
        core_req = 1'b0;
        #1;
        chk("post_old_data", core_rdata, ref_mem[8'h20]);

        // Core streaming: 8 back-to-back reads from 0
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            core_req  = (i < 8);
            core_addr = 16'(i);
            #1;
            if (i < 8) chk("str_gnt", 32'(core_gnt), 1);
            if (i > 0) begin
                chk("str_rvalid", 32'(core_rvalid), 1);
                tmp = ref_mem[i-1];
                chk("str_rdata", core_rdata, tmp);
            end
        end
        @(negedge clk);
        #1;
        chk("str_end_rvalid", 32'(core_rvalid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Shares one single-port, 1-cycle-latency SRAM between the SPI client's clock-domain-synchronised request pulses and an on-chip core requester. It sits directly behind `spi_client` on the `clk` side:
- captures `write_new` / `read_sync` together with `code`, `current_address` and `MOSI_data`;
- serves these with fixed priority over the core;
- returns read data on a held register that drives `MISO_data`.

## Interface

Parameters:
- `MESSAGE_BIT_WIDTH`, 32: data width of SPI words and SRAM words.
- `CODE_BIT_WIDTH`, 4: width of the SPI code field.
- `ADDRESS_BIT_WIDTH`, 16: SRAM and SPI address width.
- `MEM_CODE`, 1: SPI code served by this arbiter. Requests with any other code are ignored.

Ports:
- `clk`  in  1: system clock. One clock; every register is on its rising edge.
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `spi_write_new`  in  1: single-cycle pulse. SPI write word is ready.
- `spi_read_sync`  in  1: single-cycle pulse. SPI client needs the read word at `spi_address`.
- `spi_code`  in  `CODE_BIT_WIDTH`: code field of the current SPI instruction.
- `spi_address`  in  `ADDRESS_BIT_WIDTH`: SPI word address.
- `spi_wdata`  in  `MESSAGE_BIT_WIDTH`: SPI write word.
- `spi_rdata`  out  `MESSAGE_BIT_WIDTH`: last SPI read word, held. Connects to `MISO_data`.
- `spi_overrun`  out  1: sticky flag. A new SPI request arrived while the previous one was still pending.
- `core_req`  in  1: core requests access.
- `core_we`  in  1: core write (1) or read (0).
- `core_addr`  in  `ADDRESS_BIT_WIDTH`: core address.
- `core_wdata`  in  `MESSAGE_BIT_WIDTH`: core write data.
- `core_gnt`  out  1: core command accepted this cycle.
- `core_rvalid`  out  1: `core_rdata` is valid this cycle.
- `core_rdata`  out  `MESSAGE_BIT_WIDTH`: core read data.
- `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`  out: SRAM command.
- `mem_rdata`  in  `MESSAGE_BIT_WIDTH`: SRAM read data, valid the cycle after a read command.
- `overrun_clear`  in  1: clears `spi_overrun`.

## Operation

- **SPI capture.** A pulse is accepted only when `spi_code == MEM_CODE`. On acceptance the 1-entry pending buffer registers `{is_write, address, wdata}` and sets `pending_valid`.
- **Simultaneous SPI pulses.** If `spi_write_new` and `spi_read_sync` are high in the same cycle, the write is captured and `spi_overrun` is set.
- **Pulse while pending.** If an accepted pulse arrives while `pending_valid` is already 1 and the buffer is not being drained that cycle, the new pulse is dropped and `spi_overrun` is set. If the buffer drains in that same cycle, the new pulse is captured and no overrun is flagged.
- **Arbitration.** Combinational, one command per cycle, in this order:
  - `pending_valid = 1`: issue the SPI command and clear `pending_valid`.
  - otherwise `core_req = 1`: issue the core command and assert `core_gnt`.
  - otherwise: `mem_en = 0`.
- **Core grant.** `core_gnt = core_req & ~pending_valid`. The core holds its request until granted. Starvation is impossible because SPI requests arrive at most once per `MESSAGE_BIT_WIDTH` SCK periods.
- **Read tracking.** A registered grant tag `{GNT_NONE, GNT_SPI_RD, GNT_CORE_RD}` records the owner of the in-flight read.
  - `GNT_CORE_RD`: the next cycle asserts `core_rvalid` with `core_rdata = mem_rdata`.
  - `GNT_SPI_RD`: the next cycle loads `spi_rdata <= mem_rdata`.
  - Writes produce no return.
- **Overrun clear.** `overrun_clear` clears `spi_overrun`. A new overrun event in the same cycle takes precedence and keeps the flag set.

## Timing

- **Reset values.** All zero: `pending_valid`, grant tag = `GNT_NONE`, `spi_rdata`, `spi_overrun`, `core_rvalid`. `mem_en` and `core_gnt` are 0 during reset.
- **Reset mid-operation.** Pending requests and in-flight reads are discarded. No `core_rvalid` is produced for them.
- **SPI write latency.** Pulse in cycle 0 → `mem_en = mem_we = 1` in cycle 1.
- **SPI read latency.** Pulse in cycle 0 → SRAM read in cycle 1 → `mem_rdata` in cycle 2 → `spi_rdata` valid from cycle 3. This is well inside one SCK half-period for SCK ≤ `clk`/8.
- **Core read latency.** Grant in cycle N → `core_rvalid` in cycle N+1.
- **Core throughput.** Back-to-back core grants are allowed every cycle.
- **`spi_rdata` hold.** `spi_rdata` changes only on SPI read returns.

## Structure

- **Package `spi_mem_arbiter_pkg`:** grant-tag enum `grant_tag_t` and the pending-request struct `{is_write, address, wdata}`. The struct is parameterised via the package widths.
- **Sub-module `spi_request_buffer`:** 1-entry capture register with code filtering, the drain handshake, and overrun detection. The top level holds the arbitration mux, the grant tag and read-return routing.

## Test plan

- **Reset state.** Assert `rst_n = 0` mid-stream with `pending_valid = 1` → all outputs zero, no later `mem_en` for the dropped request.
- **SPI write.** `spi_write_new` with code 1, addr `0x0010`, data `0xDEADBEEF` → cycle+1: `mem_en = 1`, `mem_we = 1`, `mem_addr = 0x0010`, `mem_wdata = 0xDEADBEEF`.
- **SPI read during core traffic.** `core_req` held high, read pulse at addr `0x0010` → core loses exactly one grant cycle; `spi_rdata = 0xDEADBEEF` 3 cycles after the pulse; `core_rvalid` never set for the SPI read.
- **Code filter.** Pulse with code 2 → no `mem_en`, no `spi_overrun`.
- **Overrun.** Write and read pulses in the same cycle → write issued, `spi_overrun = 1` until `overrun_clear`.
- **Core streaming.** 8 back-to-back core reads from addr `0x0000` → 8 consecutive `core_rvalid` cycles, data matching a preloaded SRAM model.
